// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU core: opcodes, FSM states and the
// bit position used for the auxiliary (nibble) carry.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    NOP, ADD, ADDC, SUBB, INC, DEC, AND, OR,
    XOR, CPL, RL, RLC, RR, RRC, MUL, DIV
  } opcode_e;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  localparam int AC_BIT = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between operand fetch and write-back.
interface alu_seq_if
  import alu_seq_pkg::*;
#(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  opcode_e          op_code;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             srcCy;
  logic             srcAc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] des1;
  logic [WIDTH-1:0] des2;
  logic             desCy;
  logic             desAc;
  logic             desOv;

  modport master (
    output in_valid, op_code, src1, src2, srcCy, srcAc, out_ready,
    input  in_ready, out_valid, des1, des2, desCy, desAc, desOv
  );

  modport slave (
    input  in_valid, op_code, src1, src2, srcCy, srcAc, out_ready,
    output in_ready, out_valid, des1, des2, desCy, desAc, desOv
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// accumulator. hi/lo are the values the current iteration produces, so the
// caller can register the final result on the same edge that done is high.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic             busy, div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, bop;
  logic [WIDTH:0]   msum, sh, dtry;
  logic             fits;

  // Multiply shifts {acc,q} right; divide shifts it left and trial-subtracts.
  assign msum = {1'b0, acc} + (q[0] ? {1'b0, bop} : '0);
  assign sh   = {acc, q[WIDTH-1]};
  assign dtry = sh - {1'b0, bop};
  assign fits = ~dtry[WIDTH];

  always_comb begin
    if (div) begin
      hi = fits ? dtry[WIDTH-1:0] : sh[WIDTH-1:0];
      lo = {q[WIDTH-2:0], fits};
    end else begin
      hi = msum[WIDTH:1];
      lo = {msum[0], q[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
      div  <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      q    <= '0;
      bop  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      div  <= is_div;
      cnt  <= '0;
      acc  <= '0;
      q    <= a;
      bop  <= b;
    end else if (busy) begin
      acc <= hi;
      q   <= lo;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus iterative MUL/DIV,
// with results held in output registers until the consumer takes them.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic    clk,
  input logic    rst,
  alu_seq_if.slave bus
);
  state_e           state;
  logic             accept, is_md, cin;
  logic [WIDTH:0]   sum, dif;
  logic [AC_BIT+1:0] nsum, ndif;
  logic [WIDTH-1:0] r1;
  logic             rcy, rac, rov;
  logic             md_done, md_div, md_ac, md_dz;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign bus.in_ready = rst && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign is_md  = (bus.op_code == MUL) || (bus.op_code == DIV);

  assign cin  = (bus.op_code == ADDC) && bus.srcCy;
  assign sum  = {1'b0, bus.src1} + {1'b0, bus.src2} + {{WIDTH{1'b0}}, cin};
  assign dif  = {1'b0, bus.src1} - {1'b0, bus.src2} - {{WIDTH{1'b0}}, bus.srcCy};
  assign nsum = {1'b0, bus.src1[AC_BIT:0]} + {1'b0, bus.src2[AC_BIT:0]}
              + {{(AC_BIT+1){1'b0}}, cin};
  assign ndif = {1'b0, bus.src1[AC_BIT:0]} - {1'b0, bus.src2[AC_BIT:0]}
              - {{(AC_BIT+1){1'b0}}, bus.srcCy};

  always_comb begin
    r1  = bus.src1;
    rcy = bus.srcCy;
    rac = bus.srcAc;
    rov = 1'b0;
    case (bus.op_code)
      ADD, ADDC: begin
        r1  = sum[WIDTH-1:0];
        rcy = sum[WIDTH];
        rac = nsum[AC_BIT+1];
        rov = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (sum[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      SUBB: begin
        r1  = dif[WIDTH-1:0];
        rcy = dif[WIDTH];
        rac = ndif[AC_BIT+1];
        rov = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (dif[WIDTH-1] != bus.src1[WIDTH-1]);
      end
      INC: r1 = bus.src1 + WIDTH'(1);
      DEC: r1 = bus.src1 - WIDTH'(1);
      AND: r1 = bus.src1 & bus.src2;
      OR:  r1 = bus.src1 | bus.src2;
      XOR: r1 = bus.src1 ^ bus.src2;
      CPL: r1 = ~bus.src1;
      RL:  r1 = {bus.src1[WIDTH-2:0], bus.src1[WIDTH-1]};
      RR:  r1 = {bus.src1[0], bus.src1[WIDTH-1:1]};
      RLC: begin
        r1  = {bus.src1[WIDTH-2:0], bus.srcCy};
        rcy = bus.src1[WIDTH-1];
      end
      RRC: begin
        r1  = {bus.srcCy, bus.src1[WIDTH-1:1]};
        rcy = bus.src1[0];
      end
      default: ;
    endcase
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_md),
    .is_div (bus.op_code == DIV),
    .a      (bus.src1),
    .b      (bus.src2),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Result registers change only on accept, MUL/DIV completion or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.des1      <= '0;
      bus.des2      <= '0;
      bus.desCy     <= 1'b0;
      bus.desAc     <= 1'b0;
      bus.desOv     <= 1'b0;
      md_div        <= 1'b0;
      md_ac         <= 1'b0;
      md_dz         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept && is_md) begin
            state         <= ITER;
            bus.out_valid <= 1'b0;
            md_div        <= (bus.op_code == DIV);
            md_ac         <= bus.srcAc;
            md_dz         <= (bus.src2 == '0);
          end else if (accept) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.des1      <= r1;
            bus.des2      <= '0;
            bus.desCy     <= rcy;
            bus.desAc     <= rac;
            bus.desOv     <= rov;
          end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        ITER: begin
          if (md_done) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.des1      <= md_lo;
            bus.des2      <= md_hi;
            bus.desCy     <= 1'b0;
            bus.desAc     <= md_ac;
            bus.desOv     <= md_div ? md_dz : (md_hi != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed checks of alu_seq_core: a vector table of single-cycle ops plus
// hand-written MUL/DIV latency, back-pressure, reset and 16-bit sequences.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq_core #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
  alu_seq_core #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    opcode_e    op;
    logic [7:0] s1, s2;
    logic       cy, ac;
    logic [7:0] e1;
    logic       ecy, eac, eov;
  } vec_t;

  vec_t vecs[16];
  int pass = 0;
  int total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input opcode_e op, input logic [7:0] s1, input logic [7:0] s2,
                        input logic cy, input logic ac);
    b8.in_valid = 1'b1;
    b8.op_code  = op;
    b8.src1     = s1;
    b8.src2     = s2;
    b8.srcCy    = cy;
    b8.srcAc    = ac;
    #1;
  endtask

  // Accepts a MUL/DIV, checks ITER quiet period and exact WIDTH-edge latency.
  task automatic run_md(input string nm, input opcode_e op, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] e1, input logic [7:0] e2,
                        input logic eov);
    drive8(op, s1, s2, 1'b1, 1'b1);
    chk({nm, " in_ready_accept"}, b8.in_ready, 1);
    step();
    b8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({nm, " out_valid_iter"}, b8.out_valid, 0);
      chk({nm, " in_ready_iter"}, b8.in_ready, 0);
      step();
    end
    chk({nm, " out_valid"}, b8.out_valid, 1);
    chk({nm, " des1"}, b8.des1, e1);
    chk({nm, " des2"}, b8.des2, e2);
    chk({nm, " desCy"}, b8.desCy, 0);
    chk({nm, " desOv"}, b8.desOv, eov);
  endtask

  initial begin
    vecs[0]  = '{ADD,  8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{ADDC, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{SUBB, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{RLC,  8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{NOP,  8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{INC,  8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{DEC,  8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{AND,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OR,   8'hF0, 8'h3C, 1'b1, 1'b0, 8'hFC, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{XOR,  8'hF0, 8'h3C, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{CPL,  8'h5A, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{RL,   8'h81, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{RR,   8'h81, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{RRC,  8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{SUBB, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{ADD,  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b1; b8.op_code = NOP;
    b8.src1 = '0; b8.src2 = '0; b8.srcCy = 1'b0; b8.srcAc = 1'b0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.op_code = NOP;
    b16.src1 = '0; b16.src2 = '0; b16.srcCy = 1'b0; b16.srcAc = 1'b0;
    step();
    step();
    chk("reset out_valid", b8.out_valid, 0);
    chk("reset in_ready", b8.in_ready, 0);
    chk("reset des1", b8.des1, 0);
    rst = 1'b1;
    #1;
    chk("idle in_ready", b8.in_ready, 1);

    // Back-to-back single-cycle ops: each result valid one edge after accept.
    for (int i = 0; i < 16; i++) begin
      drive8(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].cy, vecs[i].ac);
      chk($sformatf("v%0d in_ready", i), b8.in_ready, 1);
      step();
      chk($sformatf("v%0d out_valid", i), b8.out_valid, 1);
      chk($sformatf("v%0d des1", i), b8.des1, vecs[i].e1);
      chk($sformatf("v%0d des2", i), b8.des2, 0);
      chk($sformatf("v%0d desCy", i), b8.desCy, vecs[i].ecy);
      chk($sformatf("v%0d desAc", i), b8.desAc, vecs[i].eac);
      chk($sformatf("v%0d desOv", i), b8.desOv, vecs[i].eov);
    end

    // MUL accepted from DONE: out_valid must drop after the accept edge.
    run_md("mul_ff", MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1);
    chk("mul_ff desAc", b8.desAc, 1);
    run_md("div_fb_12", DIV, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0);
    run_md("div_by0", DIV, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1);
    run_md("mul_small", MUL, 8'h0C, 8'h0B, 8'h84, 8'h00, 1'b0);

    // Back-pressure with a pending XOR request.
    drive8(ADD, 8'h10, 8'h20, 1'b0, 1'b0);
    step();
    b8.out_ready = 1'b0;
    drive8(XOR, 8'hF0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp in_ready", b8.in_ready, 0);
      step();
      chk("bp out_valid", b8.out_valid, 1);
      chk("bp des1", b8.des1, 8'h30);
    end
    b8.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", b8.in_ready, 1);
    step();
    chk("bp xor out_valid", b8.out_valid, 1);
    chk("bp xor des1", b8.des1, 8'hCC);
    b8.in_valid = 1'b0;
    step();
    chk("drain out_valid", b8.out_valid, 0);
    chk("drain des1 held", b8.des1, 8'hCC);

    // Reset in the middle of a MUL.
    drive8(MUL, 8'h0F, 8'h0F, 1'b1, 1'b1);
    step();
    b8.in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst in_ready low", b8.in_ready, 0);
    step();
    chk("rst out_valid", b8.out_valid, 0);
    chk("rst des1", b8.des1, 0);
    chk("rst des2", b8.des2, 0);
    chk("rst flags", {b8.desCy, b8.desAc, b8.desOv}, 0);
    rst = 1'b1;
    #1;
    chk("post rst in_ready", b8.in_ready, 1);
    for (int i = 0; i < 10; i++) step();
    chk("post rst no stale result", b8.out_valid, 0);

    // 16-bit instance: carry out of the top and the nibble boundary.
    b16.in_valid = 1'b1; b16.op_code = ADD;
    b16.src1 = 16'hFFFF; b16.src2 = 16'h0001; b16.srcCy = 1'b0; b16.srcAc = 1'b0;
    #1;
    chk("w16 in_ready", b16.in_ready, 1);
    step();
    b16.in_valid = 1'b0;
    chk("w16 out_valid", b16.out_valid, 1);
    chk("w16 des1", b16.des1, 0);
    chk("w16 desCy", b16.desCy, 1);
    chk("w16 desAc", b16.desAc, 1);
    chk("w16 desOv", b16.desOv, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
